eight_bit_adder: RTL and testbench
==================================

EIGHT_BIT_ADDER -- requirements
Module: eight_bit_adder

Interface
REQ-001 Parameter DATA_W, default 8, adder operand width; parameter IDX_W, default 4, step-counter width.
REQ-002 One clock; reset is synchronous and active-high; clock port clk, reset port res.
REQ-003 clk  input  1  rising-edge clock for the step counter.
REQ-004 res  input  1  synchronous, active-high reset.
REQ-005 a  input  8  first addend (partial-remainder high byte in divider use).
REQ-006 b  input  8  second addend (divisor or its one's complement).
REQ-007 cin  input  1  carry-in (1 = subtract via one's-complement b).
REQ-008 sum  output  9  {carry-out, 8-bit sum}, combinational.
REQ-009 step  input  1  advance step counter by one on this clock edge.
REQ-010 index  output  4  registered step count.
REQ-011 next_index  output  4  index+1, combinational.
REQ-012 last  output  1  high when index == 7.
REQ-013 done  output  1  high when index[3] == 1.

Function
REQ-014 sum SHALL equal a + b + cin as a 9-bit unsigned result; sum[8] is carry-out; zero clock latency.
REQ-015 Adder SHALL be an 8-stage ripple-carry of full-adder cells; sum[8] = carry-out of bit 7.
REQ-016 Subtraction: a + ~y + 1 SHALL give a - y in sum[7:0]; sum[8] = 1 iff a >= y (unsigned).
REQ-017 next_index SHALL equal (index + 1) mod 16; 4'hF -> 4'h0, no carry-out port.
REQ-018 On rising clk with res=0, step=1, done=0: index <= next_index.
REQ-019 With step=0: index holds.
REQ-020 With done=1: step ignored; index holds at 8 (no wrap inside the block).
REQ-021 last = index[2] & index[1] & index[0] & ~index[3]; done = index[3]; both combinational from index.
REQ-022 Adder path SHALL be independent of clk, res, step; valid during reset.
REQ-023 No X-propagation: all outputs defined for all defined inputs.

Reset
REQ-024 res=1 at rising clk SHALL force index = 0 regardless of step; res has priority over step.
REQ-025 After reset: index=0, next_index=1, last=0, done=0; sum unaffected (combinational).
REQ-026 Reset asserted mid-count SHALL abort the count; counting restarts from 0 on the first step after res deasserts.
REQ-027 Power-up index value SHALL be 0 (initialised) for simulation; hardware relies on res.

Structure
REQ-028 Shared package SHALL hold DATA_W=8, IDX_W=4, LAST_IDX=7 constants.
REQ-029 Sub-module index_adder (input index[3:0], output next_index[3:0]) SHALL implement the half-adder incrementer chain; instantiated once.
REQ-030 Full-adder cell SHALL be a generate loop within eight_bit_adder, not a separate module.
REQ-031 Port order of the adder portion SHALL be (sum, a, b, cin) for positional instantiation by the divider.

Verification
REQ-032 a=8'hFF, b=8'h01, cin=0 -> sum=9'h100; a=8'h00, b=8'h00, cin=1 -> sum=9'h001.
REQ-033 a=8'h05, b=8'hFC, cin=1 -> sum=9'h102 (5-3=2, carry 1); a=8'h03, b=8'hFA, cin=1 -> sum=9'h0FE (3-5, carry 0).
REQ-034 res pulse, then step=1 for 10 edges -> index 0,1..8 then holds 8; last=1 only at index=7; done=1 from index=8.
REQ-035 step=1 continuously, res=1 on the edge where index=5 -> index=0 next cycle; step resumes 1,2,...
REQ-036 index_adder standalone, sweep 0..15 -> next_index = input+1, 4'hF -> 4'h0.
REQ-037 step=0 for 3 edges mid-count at index=4 -> index stays 4, last=0, done=0.

Source files
------------

// File: rtl/eight_bit_adder_pkg.sv
// Shared constants for the divider datapath slice.
// Holds the adder width, the step-counter width and the final step index.
package eight_bit_adder_pkg;
  localparam int DATA_W   = 8;
  localparam int IDX_W    = 4;
  localparam int LAST_IDX = 7;
endpackage

// File: rtl/eight_bit_adder_if.sv
// Bundle of the adder operands/result and the step-counter signals.
// The master side drives operands and step; the slave side returns results.
interface eight_bit_adder_if
  import eight_bit_adder_pkg::*;
#(
  parameter int P_DATA_W = eight_bit_adder_pkg::DATA_W,
  parameter int P_IDX_W  = eight_bit_adder_pkg::IDX_W
);
  logic [P_DATA_W-1:0] a;
  logic [P_DATA_W-1:0] b;
  logic                cin;
  logic [P_DATA_W:0]   sum;
  logic                step;
  logic [P_IDX_W-1:0]  index;
  logic [P_IDX_W-1:0]  next_index;
  logic                last;
  logic                done;

  modport master (
    output a, b, cin, step,
    input  sum, index, next_index, last, done
  );

  modport slave (
    input  a, b, cin, step,
    output sum, index, next_index, last, done
  );
endinterface

// File: rtl/eight_bit_adder_index_adder.sv
// Half-adder incrementer chain: next_index = index + 1, wrapping at the
// counter width with no carry-out.
module index_adder #(
  parameter int IDX_W = eight_bit_adder_pkg::IDX_W
) (
  input  logic [IDX_W-1:0] index,
  output logic [IDX_W-1:0] next_index
);
  // Unpacked carry chain keeps each stage a separate net.
  logic w_carry [IDX_W+1];

  assign w_carry[0] = 1'b1;

  for (genvar gi = 0; gi < IDX_W; gi++) begin : g_ha
    assign next_index[gi]  = index[gi] ^ w_carry[gi];
    assign w_carry[gi + 1] = index[gi] & w_carry[gi];
  end
endmodule

// File: rtl/eight_bit_adder.sv
// Ripple-carry adder plus saturating step counter used by the restoring divider.
// The adder is purely combinational; the counter stops once index reaches 8.
module eight_bit_adder #(
  parameter int DATA_W = eight_bit_adder_pkg::DATA_W,
  parameter int IDX_W  = eight_bit_adder_pkg::IDX_W
) (
  output logic [DATA_W:0]   sum,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  input  logic              clk,
  input  logic              res,
  input  logic              step,
  output logic [IDX_W-1:0]  index,
  output logic [IDX_W-1:0]  next_index,
  output logic              last,
  output logic              done
);
  import eight_bit_adder_pkg::*;

  logic              w_carry [DATA_W+1];
  logic [DATA_W-1:0] w_sum;
  logic [IDX_W-1:0]  w_next_index;
  logic              w_done;
  logic              w_last;
  logic [IDX_W-1:0]  r_index = '0;

  assign w_carry[0] = cin;

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_fa
    assign w_sum[gi]       = a[gi] ^ b[gi] ^ w_carry[gi];
    assign w_carry[gi + 1] = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
  end

  assign sum = {w_carry[DATA_W], w_sum};

  index_adder #(
    .IDX_W (IDX_W)
  ) u_index_adder (
    .index      (r_index),
    .next_index (w_next_index)
  );

  assign w_done = r_index[IDX_W-1];
  assign w_last = (r_index == IDX_W'(LAST_IDX));

  // The MSB acts as a sticky "finished" flag: once set, step is ignored.
  always_ff @(posedge clk) begin
    if (res) begin
      r_index <= '0;
    end else if (step && !w_done) begin
      r_index <= w_next_index;
    end
  end

  assign index      = r_index;
  assign next_index = w_next_index;
  assign last       = w_last;
  assign done       = w_done;
endmodule

// File: tb/tb_eight_bit_adder.sv
// Directed bench for eight_bit_adder: arithmetic model checked every cycle,
// plus literal vectors for the adder, counter sequences and the incrementer.
module tb_eight_bit_adder;
  logic clk = 1'b0;
  logic res;
  int   total = 0;
  int   bad   = 0;
  int   m_idx = 0;

  always #5 clk = ~clk;

  eight_bit_adder_if bus ();

  eight_bit_adder dut (
    .sum        (bus.sum),
    .a          (bus.a),
    .b          (bus.b),
    .cin        (bus.cin),
    .clk        (clk),
    .res        (res),
    .step       (bus.step),
    .index      (bus.index),
    .next_index (bus.next_index),
    .last       (bus.last),
    .done       (bus.done)
  );

  logic [3:0] ia_in;
  logic [3:0] ia_out;

  index_adder #(.IDX_W(4)) u_ia (
    .index      (ia_in),
    .next_index (ia_out)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counter model: counts steps, saturating at 8, cleared by reset.
  always @(posedge clk) begin
    if (res) m_idx = 0;
    else if (bus.step && m_idx < 8) m_idx = m_idx + 1;
  end

  // Per-cycle comparison against plain arithmetic.
  always @(negedge clk) begin
    int exp_sum;
    exp_sum = int'(bus.a) + int'(bus.b) + int'(bus.cin);
    check("model_sum", 16'(bus.sum), 16'(exp_sum));
    check("model_index", 16'(bus.index), 16'(m_idx));
    check("model_next_index", 16'(bus.next_index), 16'((m_idx + 1) % 16));
    check("model_last", 16'(bus.last), 16'(m_idx == 7));
    check("model_done", 16'(bus.done), 16'(m_idx >= 8));
  end

  task automatic edge_wait();
    @(posedge clk);
    #2;
  endtask

  task automatic add_vec(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                         input logic [8:0] exp, input string name);
    bus.a = va; bus.b = vb; bus.cin = vc;
    #1;
    check(name, 16'(bus.sum), 16'(exp));
    $display("add a=%02h b=%02h cin=%0d sum=%03h", va, vb, vc, bus.sum);
  endtask

  logic [3:0] seq34 [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd8, 4'd8};

  initial begin
    res = 1'b1; bus.step = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    edge_wait();
    res = 1'b0;
    check("reset_index", 16'(bus.index), 16'h0);
    check("reset_next_index", 16'(bus.next_index), 16'h1);
    check("reset_last", 16'(bus.last), 16'h0);
    check("reset_done", 16'(bus.done), 16'h0);

    add_vec(8'hFF, 8'h01, 1'b0, 9'h100, "add_ff_01");
    add_vec(8'h00, 8'h00, 1'b1, 9'h001, "add_00_cin");
    add_vec(8'h05, 8'hFC, 1'b1, 9'h102, "sub_5_3");
    add_vec(8'h03, 8'hFA, 1'b1, 9'h0FE, "sub_3_5");
    add_vec(8'hA5, 8'h5A, 1'b1, 9'h100, "add_a5_5a_cin");
    add_vec(8'h80, 8'h7F, 1'b0, 9'h0FF, "add_80_7f");

    // Adder valid during reset
    res = 1'b1;
    add_vec(8'h12, 8'h34, 1'b0, 9'h046, "add_in_reset");
    edge_wait();
    res = 1'b0;

    // Count through to saturation
    bus.step = 1'b1;
    for (int i = 0; i < 10; i++) begin
      edge_wait();
      check("seq_index", 16'(bus.index), 16'(seq34[i]));
      check("seq_last", 16'(bus.last), 16'(seq34[i] == 4'd7 && i == 6));
      check("seq_done", 16'(bus.done), 16'(i >= 7));
      $display("step edge=%0d index=%0d last=%0d done=%0d", i, bus.index, bus.last, bus.done);
    end

    // Reset mid-count with step held high
    res = 1'b1; edge_wait(); res = 1'b0;
    for (int i = 1; i <= 5; i++) edge_wait();
    check("pre_abort_index", 16'(bus.index), 16'h5);
    res = 1'b1;
    edge_wait();
    check("abort_index", 16'(bus.index), 16'h0);
    res = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      edge_wait();
      check("resume_index", 16'(bus.index), 16'(i));
      $display("resume index=%0d", bus.index);
    end

    // Hold at index 4
    edge_wait();
    check("hold_pre_index", 16'(bus.index), 16'h4);
    bus.step = 1'b0;
    for (int i = 0; i < 3; i++) begin
      edge_wait();
      check("hold_index", 16'(bus.index), 16'h4);
      check("hold_last", 16'(bus.last), 16'h0);
      check("hold_done", 16'(bus.done), 16'h0);
      $display("hold index=%0d", bus.index);
    end

    // Standalone incrementer sweep
    for (int i = 0; i < 16; i++) begin
      ia_in = 4'(i);
      #1;
      check("incr_sweep", 16'(ia_out), (i == 15) ? 16'h0 : 16'(i + 1));
      $display("incr in=%0h out=%0h", ia_in, ia_out);
    end

    edge_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
